// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_pkg
//  Description : Shared types and helpers for the UART transmit arbiter.
//                Defines the hand-off FSM state encoding, the owner index
//                width and a wrap-around increment used for the round-robin
//                pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    // Owner index is always 3 bits so the port width does not depend on N.
    localparam int OWNER_W = 3;

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_WAIT_FALL = 2'd3
    } arb_state_e;

    // (i + 1) mod n for an owner-sized index.
    function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] i,
                                                    input int               n);
        if (int'(i) >= n - 1) begin
            return '0;
        end
        return i + 3'd1;
    endfunction

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_rr_pick
//  Description : Combinational N-way rotate-priority picker. Returns the first
//                set request bit scanning upward from 'start' with wrap.
//  Ports       : req   [N-1:0]  in   request vector
//                start [2:0]    in   index with highest priority (< N)
//                found          out  at least one request bit is set
//                idx   [2:0]    out  index of the selected request
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] start,
    output logic               found,
    output logic [OWNER_W-1:0] idx
);

    logic [7:0] req_ext;
    int         pos;

    // Scan from the farthest offset down to offset 0, so the last hit
    // written (the nearest one to 'start') wins.
    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        found            = 1'b0;
        idx              = '0;
        pos              = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req_ext[pos[2:0]]) begin
                found = 1'b1;
                idx   = pos[2:0];
            end
        end
    end

endmodule : uart_tx_arbiter_rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between N byte requesters using
//                round-robin arbitration with bounded bursts. Latches the
//                granted byte, pulses tx_start/ack, tracks tx_busy until the
//                frame completes, and flags a transmitter that never
//                acknowledges a start.
//  Ports       : clk               in   system clock
//                n_reset           in   asynchronous active-low reset
//                req      [N-1:0]  in   requester i has a byte ready
//                req_data [8N-1:0] in   byte of requester i at [8i+7:8i]
//                ack      [N-1:0]  out  one-cycle accept pulse
//                tx_data  [7:0]    out  byte to uart_tx, held for the frame
//                tx_start          out  one-cycle start pulse to uart_tx
//                tx_busy           in   uart_tx frame in progress
//                owner    [2:0]    out  current/last granted requester
//                active            out  byte handed off or in transmission
//                err_tmo           out  tx_busy failed to rise in time
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    parameter int ACK_TMO   = 16
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [N-1:0]       req,
    input  logic [8*N-1:0]     req_data,
    output logic [N-1:0]       ack,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [OWNER_W-1:0] owner,
    output logic               active,
    output logic               err_tmo
);

    localparam int                CNT_W       = $clog2(ACK_TMO + 1);
    localparam logic [CNT_W-1:0]  C_TMO_LAST  = CNT_W'(ACK_TMO - 1);
    localparam logic [3:0]        C_MAX_BURST = 4'(MAX_BURST);

    arb_state_e         state_q,    state_d;
    logic [OWNER_W-1:0] owner_q,    owner_d;
    logic [OWNER_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [3:0]         burst_q,    burst_d;
    logic [CNT_W-1:0]   tmo_cnt_q,  tmo_cnt_d;
    logic [7:0]         tx_data_q,  tx_data_d;
    logic [N-1:0]       ack_q,      ack_d;
    logic               tx_start_q, tx_start_d;
    logic               err_tmo_w;

    logic [7:0]         req_ext;
    logic [63:0]        data_ext;
    logic               pick_found;
    logic [OWNER_W-1:0] pick_idx;
    logic [OWNER_W-1:0] win;

    uart_tx_arbiter_rr_pick #(
        .N (N)
    ) u_pick (
        .req   (req),
        .start (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_ARB;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            burst_q    <= '0;
            tmo_cnt_q  <= '0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            burst_q    <= burst_d;
            tmo_cnt_q  <= tmo_cnt_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        burst_d    = burst_q;
        tmo_cnt_d  = tmo_cnt_q;
        tx_data_d  = tx_data_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        err_tmo_w  = 1'b0;
        win        = owner_q;

        // Widened copies so owner-sized indices never exceed the vector.
        req_ext              = '0;
        req_ext[N-1:0]       = req;
        data_ext             = '0;
        data_ext[8*N-1:0]    = req_data;

        case (state_q)
            ST_ARB: begin
                // Owner released its request: its burst is over.
                if (!req_ext[owner_q]) begin
                    burst_d = '0;
                end
                if (!tx_busy && pick_found) begin
                    if (req_ext[owner_q] && (burst_q < C_MAX_BURST)) begin
                        win     = owner_q;
                        burst_d = burst_q + 4'd1;
                    end else begin
                        win     = pick_idx;
                        burst_d = 4'd1;
                    end
                    owner_d    = win;
                    rr_ptr_d   = wrap_inc(win, N);
                    tx_data_d  = data_ext[{win, 3'b000} +: 8];
                    tx_start_d = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        ack_d[i] = (win == 3'(i));
                    end
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_FALL;
                end else if (tmo_cnt_q == C_TMO_LAST) begin
                    // Byte is dropped: the requester was already acked.
                    err_tmo_w = 1'b1;
                    burst_d   = '0;
                    state_d   = ST_ARB;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_WAIT_FALL: begin
                if (!tx_busy) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    assign ack      = ack_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign owner    = owner_q;
    assign active   = (state_q != ST_ARB);
    assign err_tmo  = err_tmo_w;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter. Instance A
//                uses MAX_BURST=4, instance B uses MAX_BURST=1. A small
//                uart_tx model raises busy one cycle after tx_start for FRAME
//                cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           n_reset;
    logic [N-1:0]   req_a, req_b, ack_a, ack_b;
    logic [8*N-1:0] data_a, data_b;
    logic [7:0]     tx_data_a, tx_data_b;
    logic           tx_start_a, tx_start_b, busy_a, busy_b;
    logic [2:0]     owner_a, owner_b;
    logic           active_a, active_b, err_a, err_b;
    logic           model_en, force_busy;
    int             bcnt_a, bcnt_b;

    uart_tx_arbiter #(.N(N), .MAX_BURST(4), .ACK_TMO(16)) dut_a (
        .clk (clk), .n_reset (n_reset), .req (req_a), .req_data (data_a),
        .ack (ack_a), .tx_data (tx_data_a), .tx_start (tx_start_a),
        .tx_busy (busy_a), .owner (owner_a), .active (active_a),
        .err_tmo (err_a)
    );

    uart_tx_arbiter #(.N(N), .MAX_BURST(1), .ACK_TMO(16)) dut_b (
        .clk (clk), .n_reset (n_reset), .req (req_b), .req_data (data_b),
        .ack (ack_b), .tx_data (tx_data_b), .tx_start (tx_start_b),
        .tx_busy (busy_b), .owner (owner_b), .active (active_b),
        .err_tmo (err_b)
    );

    // uart_tx models, reset by the same n_reset
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset)                      bcnt_a <= 0;
        else if (tx_start_a && model_en)   bcnt_a <= FRAME;
        else if (bcnt_a > 0)               bcnt_a <= bcnt_a - 1;
    end
    assign busy_a = (bcnt_a > 0) || force_busy;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset)                      bcnt_b <= 0;
        else if (tx_start_b)               bcnt_b <= FRAME;
        else if (bcnt_b > 0)               bcnt_b <= bcnt_b - 1;
    end
    assign busy_b = (bcnt_b > 0);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Grant monitor: records grant order, checks ack/tx_start pairing.
    int           order_a[$];
    int           order_b[$];
    logic [N-1:0] prev_ack_a = '0;
    logic [N-1:0] prev_ack_b = '0;

    always @(negedge clk) begin
        if (n_reset) begin
            if ((|ack_a) || tx_start_a) begin
                check("a_ack_onehot",   32'($onehot(ack_a)), 32'd1);
                check("a_start_w_ack",  32'(tx_start_a),     32'd1);
                check("a_ack_width",    32'(prev_ack_a),     32'd0);
                order_a.push_back(idx_of(ack_a));
            end
            if ((|ack_b) || tx_start_b) begin
                check("b_ack_onehot",   32'($onehot(ack_b)), 32'd1);
                check("b_start_w_ack",  32'(tx_start_b),     32'd1);
                order_b.push_back(idx_of(ack_b));
            end
        end
        prev_ack_a <= ack_a;
        prev_ack_b <= ack_b;
    end

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        req_a   = '0;
        req_b   = '0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        order_a.delete();
        order_b.delete();
    endtask

    task automatic wait_grants(input bit use_b, input int n, input int max_cyc);
        int k = 0;
        while (((use_b ? order_b.size() : order_a.size()) < n) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check(use_b ? "b_grant_count" : "a_grant_count",
              32'(use_b ? order_b.size() : order_a.size()), 32'(n));
    endtask

    task automatic wait_idle_a(input int max_cyc);
        int k = 0;
        while (active_a && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check("a_idle", 32'(active_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int act;
        int k;
        int exp2[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
        int exp3[4] = '{1, 3, 1, 3};

        n_reset    = 1'b0;
        req_a      = '0;
        req_b      = '0;
        data_a     = '0;
        data_b     = '0;
        model_en   = 1'b1;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ack",      32'(ack_a),      32'd0);
        check("rst_start",    32'(tx_start_a), 32'd0);
        check("rst_tx_data",  32'(tx_data_a),  32'd0);
        check("rst_owner",    32'(owner_a),    32'd0);
        check("rst_active",   32'(active_a),   32'd0);
        check("rst_err",      32'(err_a),      32'd0);
        n_reset = 1'b1;
        @(negedge clk);

        // 1: single request, 1-cycle latency, data held over the frame
        data_a = 32'h005A_0000;
        req_a  = 4'b0100;
        @(negedge clk);
        check("t1_ack",    32'(ack_a),      32'h4);
        check("t1_start",  32'(tx_start_a), 32'd1);
        check("t1_data",   32'(tx_data_a),  32'h5A);
        check("t1_owner",  32'(owner_a),    32'd2);
        req_a = '0;
        act   = 0;
        while (active_a && act < 40) begin
            act++;
            check("t1_hold", 32'(tx_data_a), 32'h5A);
            @(negedge clk);
        end
        // START + WAIT_RISE + 10 busy cycles
        check("t1_active_len", 32'(act), 32'd12);

        // 2: all requesters, bursts of 4
        do_reset();
        data_a = 32'h1312_1110;
        req_a  = 4'hF;
        wait_grants(1'b0, 9, 200);
        req_a = '0;
        wait_idle_a(40);
        for (int i = 0; i < 9; i++) begin
            check("t2_order", 32'((i < order_a.size()) ? order_a[i] : -1), 32'(exp2[i]));
        end

        // 3: two contenders with MAX_BURST=1 alternate
        do_reset();
        req_b = 4'b1010;
        wait_grants(1'b1, 4, 100);
        req_b = '0;
        repeat (15) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("t3_order", 32'((i < order_b.size()) ? order_b[i] : -1), 32'(exp3[i]));
        end

        // 4: tx_busy never rises -> timeout 16 cycles after tx_start
        do_reset();
        model_en = 1'b0;
        req_a    = 4'b0001;
        @(negedge clk);
        check("t4_start", 32'(tx_start_a), 32'd1);
        req_a = '0;
        k = 0;
        while (!err_a && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t4_tmo_delay", 32'(k), 32'd16);
        @(negedge clk);
        check("t4_err_width", 32'(err_a),    32'd0);
        check("t4_back_arb",  32'(active_a), 32'd0);
        model_en = 1'b1;
        data_a   = 32'h00C3_0000;
        req_a    = 4'b0100;
        @(negedge clk);
        check("t4_next_ack",  32'(ack_a),     32'h4);
        check("t4_next_data", 32'(tx_data_a), 32'hC3);
        req_a = '0;
        wait_idle_a(40);

        // 5: asynchronous reset in WAIT_FALL
        do_reset();
        data_a = 32'h0000_7700;
        req_a  = 4'b0010;
        @(negedge clk);
        check("t5_ack", 32'(ack_a), 32'h2);
        req_a = '0;
        repeat (3) @(negedge clk);
        check("t5_in_frame", 32'(active_a), 32'd1);
        n_reset = 1'b0;
        #1;
        check("t5_rst_ack",     32'(ack_a),      32'd0);
        check("t5_rst_start",   32'(tx_start_a), 32'd0);
        check("t5_rst_tx_data", 32'(tx_data_a),  32'd0);
        check("t5_rst_owner",   32'(owner_a),    32'd0);
        check("t5_rst_active",  32'(active_a),   32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        data_a  = 32'h1312_1110;
        req_a   = 4'hF;
        @(negedge clk);
        check("t5_restart_ack",   32'(ack_a),     32'h1);
        check("t5_restart_owner", 32'(owner_a),   32'd0);
        check("t5_restart_data",  32'(tx_data_a), 32'h10);
        req_a = '0;
        wait_idle_a(40);

        // 6: foreign busy in ARB blocks the grant
        do_reset();
        force_busy = 1'b1;
        req_a      = 4'b0001;
        repeat (5) begin
            @(negedge clk);
            check("t6_no_ack", 32'(ack_a), 32'd0);
        end
        force_busy = 1'b0;
        @(negedge clk);
        check("t6_ack",   32'(ack_a),      32'h1);
        check("t6_start", 32'(tx_start_a), 32'd1);
        req_a = '0;
        wait_idle_a(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
